// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data memory load/store unit.
// Holds the access FSM state encoding and the address fault check.
package data_mem_pkg;

   localparam int DWORD_W    = 64;
   localparam int BYTE_OFF_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_DONE  = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

   // Misaligned or beyond the 2^aw doubleword window.
   function automatic logic addr_fault(
      input logic [DWORD_W-1:0] addr,
      input int                 aw
   );
      logic [DWORD_W-1:0] hi;
      hi = addr >> (aw + BYTE_OFF_W);
      return (|addr[BYTE_OFF_W-1:0]) || (|hi);
   endfunction

endpackage

// File: rtl/data_mem_wbuf.sv
// One-entry posted-write buffer for the data memory load/store unit.
// Only instantiated when DATA_MEM_CTRL_POSTED_WRITE_EN is defined.
module data_mem_wbuf
   import data_mem_pkg::*;
#(
   parameter int ADDR_W = 5
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_push,
   input  logic [ADDR_W-1:0]  i_addr,
   input  logic [DWORD_W-1:0] i_data,
   input  logic               i_pop,
   output logic               o_busy,
   output logic [ADDR_W-1:0]  o_addr,
   output logic [DWORD_W-1:0] o_data
);

   logic               r_valid;
   logic [ADDR_W-1:0]  r_addr;
   logic [DWORD_W-1:0] r_data;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_valid <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
      end else if (i_push) begin
         r_valid <= 1'b1;
         r_addr  <= i_addr;
         r_data  <= i_data;
      end else if (i_pop) begin
         r_valid <= 1'b0;
      end
   end

   assign o_busy = r_valid;
   assign o_addr = r_addr;
   assign o_data = r_data;

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store unit: CPU level controls -> req/ack doubleword RAM, with stall and fault.
// Optional zero-stall stores via DATA_MEM_CTRL_POSTED_WRITE_EN.
module data_mem_ctrl
   import data_mem_pkg::*;
#(
   parameter int ADDR_W  = 5,
   parameter int TIMEOUT = 15
) (
   input  logic               CLOCK,
   input  logic               RESET_N,
   input  logic               CPU_MEMREAD,
   input  logic               CPU_MEMWRITE,
   input  logic [DWORD_W-1:0] CPU_ADDRESS,
   input  logic [DWORD_W-1:0] CPU_WDATA,
   output logic [DWORD_W-1:0] CPU_RDATA,
   output logic               STALL,
   output logic               FAULT,
   output logic               MEM_REQ,
   output logic               MEM_WE,
   output logic [ADDR_W-1:0]  MEM_ADDR,
   output logic [DWORD_W-1:0] MEM_WDATA,
   input  logic               MEM_ACK,
   input  logic [DWORD_W-1:0] MEM_RDATA
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_t             r_state;
   logic               r_mem_req;
   logic               r_mem_we;
   logic [ADDR_W-1:0]  r_mem_addr;
   logic [DWORD_W-1:0] r_mem_wdata;
   logic [DWORD_W-1:0] r_rdata;
   logic               r_fault;
   logic [CNT_W-1:0]   r_cnt;

   logic               w_req;
   logic               w_flt;
   logic               w_idle;
   logic               w_in_req;
   logic               w_tmo;
   logic [ADDR_W-1:0]  w_idx;

   assign w_req    = CPU_MEMREAD | CPU_MEMWRITE;
   assign w_flt    = addr_fault(CPU_ADDRESS, ADDR_W);
   assign w_idle   = (r_state == ST_IDLE);
   assign w_in_req = (r_state == ST_REQ);
   assign w_tmo    = (r_cnt == CNT_W'(TIMEOUT - 1));
   assign w_idx    = CPU_ADDRESS[ADDR_W+BYTE_OFF_W-1:BYTE_OFF_W];

`ifdef DATA_MEM_CTRL_POSTED_WRITE_EN
   logic               r_posted;
   logic               w_post;
   logic               w_pop;
   logic               w_wb_busy;
   logic [ADDR_W-1:0]  w_wb_addr;
   logic [DWORD_W-1:0] w_wb_data;

   assign w_post = w_idle & CPU_MEMWRITE & ~w_flt & ~w_wb_busy;
   assign w_pop  = w_in_req & r_posted & (MEM_ACK | w_tmo);

   data_mem_wbuf #(
      .ADDR_W (ADDR_W)
   ) u_wbuf (
      .i_clk   (CLOCK),
      .i_rst_n (RESET_N),
      .i_push  (w_post),
      .i_addr  (w_idx),
      .i_data  (CPU_WDATA),
      .i_pop   (w_pop),
      .o_busy  (w_wb_busy),
      .o_addr  (w_wb_addr),
      .o_data  (w_wb_data)
   );

   // A drain runs behind the CPU; only a new request has to wait for it.
   assign STALL = (w_idle & w_req & ~w_flt & ~w_post)
                | (w_in_req & (~r_posted | w_req))
                | ((r_state == ST_FAULT) & r_posted & w_req);
   assign MEM_ADDR  = r_posted ? w_wb_addr : r_mem_addr;
   assign MEM_WDATA = r_posted ? w_wb_data : r_mem_wdata;
`else
   assign STALL     = (w_idle & w_req & ~w_flt) | w_in_req;
   assign MEM_ADDR  = r_mem_addr;
   assign MEM_WDATA = r_mem_wdata;
`endif

   assign MEM_REQ   = r_mem_req;
   assign MEM_WE    = r_mem_we;
   assign CPU_RDATA = r_rdata;
   assign FAULT     = r_fault;

   always_ff @(posedge CLOCK) begin
      if (!RESET_N) begin
         r_state     <= ST_IDLE;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_rdata     <= '0;
         r_fault     <= 1'b0;
         r_cnt       <= '0;
`ifdef DATA_MEM_CTRL_POSTED_WRITE_EN
         r_posted    <= 1'b0;
`endif
      end else begin
         r_fault <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               r_cnt <= '0;
               if (w_req && w_flt) begin
                  r_state <= ST_FAULT;
                  r_fault <= 1'b1;
                  if (!CPU_MEMWRITE) r_rdata <= '0;
               end else if (w_req) begin
                  r_state     <= ST_REQ;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= CPU_MEMWRITE;
                  r_mem_addr  <= w_idx;
                  r_mem_wdata <= CPU_WDATA;
`ifdef DATA_MEM_CTRL_POSTED_WRITE_EN
                  r_posted    <= w_post;
`endif
               end
            end
            ST_REQ: begin
               if (MEM_ACK) begin
                  r_mem_req <= 1'b0;
                  if (!r_mem_we) r_rdata <= MEM_RDATA;
`ifdef DATA_MEM_CTRL_POSTED_WRITE_EN
                  r_state   <= r_posted ? ST_IDLE : ST_DONE;
                  r_posted  <= 1'b0;
`else
                  r_state   <= ST_DONE;
`endif
               end else if (w_tmo) begin
                  r_mem_req <= 1'b0;
                  r_rdata   <= '0;
                  r_state   <= ST_FAULT;
                  r_fault   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            ST_FAULT: begin
               r_state  <= ST_IDLE;
`ifdef DATA_MEM_CTRL_POSTED_WRITE_EN
               r_posted <= 1'b0;
`endif
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized bench for data_mem_ctrl against a transaction-level model.
// Covers the posted-write path when DATA_MEM_CTRL_POSTED_WRITE_EN is defined.
module tb_data_mem_ctrl;

   localparam int AW = 5;
   localparam int TO = 15;
   localparam int NW = 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic        ack = 1'b0;
   logic [63:0] addr = '0;
   logic [63:0] wdata = '0;
   logic [63:0] mrdata = '0;
   logic [63:0] cpu_rdata;
   logic        stall;
   logic        fault;
   logic        mreq;
   logic        mwe;
   logic [4:0]  maddr;
   logic [63:0] mwdata;

   logic [63:0] ram     [NW];
   logic [63:0] ref_ram [NW];
   logic [63:0] exp_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   data_mem_ctrl #(
      .ADDR_W  (AW),
      .TIMEOUT (TO)
   ) dut (
      .CLOCK        (clk),
      .RESET_N      (rst_n),
      .CPU_MEMREAD  (rd),
      .CPU_MEMWRITE (wr),
      .CPU_ADDRESS  (addr),
      .CPU_WDATA    (wdata),
      .CPU_RDATA    (cpu_rdata),
      .STALL        (stall),
      .FAULT        (fault),
      .MEM_REQ      (mreq),
      .MEM_WE       (mwe),
      .MEM_ADDR     (maddr),
      .MEM_WDATA    (mwdata),
      .MEM_ACK      (ack),
      .MEM_RDATA    (mrdata)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One CPU access; dly = REQ cycles before the ack (>= TO means never).
   task automatic access(input logic r, input logic w,
                         input logic [63:0] a, input logic [63:0] d,
                         input int dly);
      int          stalls, reqs, faults, e_st, e_rq, e_ft;
      bit          first, ended, flt;
      logic [4:0]  idx;
      logic [63:0] rd_done;
      flt = (a[2:0] != 3'd0) || (a >= 64'(NW * 8));
      idx = a[7:3];
      rd = r; wr = w; addr = a; wdata = d;
      stalls = 0; reqs = 0; faults = 0;
      first = 1'b1; ended = 1'b0; rd_done = '0;
      for (int c = 0; c < 40 && !ended; c++) begin
         @(negedge clk);
         mrdata = {$urandom, $urandom};
         if (mreq) begin
            if (first) begin
               check("mem_addr", 64'(maddr), 64'(idx));
               check("mem_we", 64'(mwe), 64'(w));
               if (w) check("mem_wdata", mwdata, d);
               first = 1'b0;
            end
            if (reqs == dly) begin
               ack = 1'b1;
               if (mwe) ram[maddr] = mwdata;
               else mrdata = ram[maddr];
            end
            reqs++;
         end
         if (fault) faults++;
         if (stall) stalls++;
         else begin
            ended = 1'b1;
            rd_done = cpu_rdata;
         end
         @(posedge clk); #1;
         ack = 1'b0;
      end
      check("stall_bound", 64'(ended), 64'd1);
      rd = 1'b0; wr = 1'b0;
      addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         if (mreq) reqs++;
         if (fault) faults++;
         if (stall) stalls++;
         @(posedge clk); #1;
      end
      if (flt) begin
         e_st = 0; e_rq = 0; e_ft = 1;
         if (r && !w) exp_rdata = '0;
      end else if (dly >= TO) begin
         e_st = TO + 1; e_rq = TO; e_ft = 1;
         exp_rdata = '0;
      end else begin
         e_st = dly + 2; e_rq = dly + 1; e_ft = 0;
         if (w) ref_ram[idx] = d;
         else begin
            exp_rdata = ref_ram[idx];
            check("rdata_done", rd_done, exp_rdata);
         end
      end
      check("stalls", 64'(stalls), 64'(e_st));
      check("req_cycles", 64'(reqs), 64'(e_rq));
      check("fault_pulses", 64'(faults), 64'(e_ft));
      check("rdata_hold", cpu_rdata, exp_rdata);
      if (w && !flt) check("ram_word", ram[idx], ref_ram[idx]);
   endtask

   initial begin
      logic [63:0] v, a;
      logic        r, w;
      int          kind, dly, st, wreqs;
      bit          done;

      for (int i = 0; i < NW; i++) begin
         v = {$urandom, $urandom};
         ram[i] = v;
         ref_ram[i] = v;
      end
      ram[10] = 64'd1540;
      ref_ram[10] = 64'd1540;
      exp_rdata = '0;

      @(posedge clk); @(posedge clk);
      @(negedge clk);
      check("rst_req", 64'(mreq), 64'd0);
      check("rst_we", 64'(mwe), 64'd0);
      check("rst_addr", 64'(maddr), 64'd0);
      check("rst_wdata", mwdata, 64'd0);
      check("rst_rdata", cpu_rdata, 64'd0);
      check("rst_fault", 64'(fault), 64'd0);
      check("rst_stall", 64'(stall), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      access(1'b1, 1'b0, 64'h50, 64'd0, 0);
      check("tp_load", cpu_rdata, 64'd1540);
`ifndef DATA_MEM_CTRL_POSTED_WRITE_EN
      access(1'b0, 1'b1, 64'h38, 64'd4, 3);
      check("tp_store", ram[7], 64'd4);
`endif
      access(1'b1, 1'b0, 64'h51, 64'd0, 0);
      access(1'b1, 1'b0, 64'h100, 64'd0, 0);
      access(1'b1, 1'b0, 64'h18, 64'd0, 99);

      // abandon a load mid-REQ and feed it a stale ack
      rd = 1'b1; addr = 64'h20;
      @(posedge clk); #1;
      @(negedge clk);
      check("mid_req", 64'(mreq), 64'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1; rd = 1'b0;
      exp_rdata = '0;
      @(negedge clk);
      check("rst_mid_req", 64'(mreq), 64'd0);
      check("rst_mid_stall", 64'(stall), 64'd0);
      ack = 1'b1; mrdata = 64'hdead_beef_0bad_cafe;
      @(posedge clk); #1;
      ack = 1'b0;
      @(negedge clk);
      check("late_ack_req", 64'(mreq), 64'd0);
      check("late_ack_fault", 64'(fault), 64'd0);
      check("late_ack_rdata", cpu_rdata, 64'd0);
      @(posedge clk); #1;

`ifdef DATA_MEM_CTRL_POSTED_WRITE_EN
      v = {$urandom, $urandom};
      ref_ram[8] = v;
      wr = 1'b1; addr = 64'h40; wdata = v;
      @(negedge clk);
      check("post_stall", 64'(stall), 64'd0);
      @(posedge clk); #1;
      wr = 1'b0; rd = 1'b1;
      st = 0; wreqs = 0; done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (mreq) begin
            if (mwe) begin
               if (wreqs == 2) begin
                  ack = 1'b1;
                  ram[maddr] = mwdata;
               end
               wreqs++;
            end else begin
               ack = 1'b1;
               mrdata = ram[maddr];
            end
         end
         if (stall) st++;
         else begin
            done = 1'b1;
            check("post_rdata", cpu_rdata, v);
         end
         @(posedge clk); #1;
         ack = 1'b0;
      end
      rd = 1'b0;
      exp_rdata = v;
      check("post_bound", 64'(done), 64'd1);
      check("post_stalls", 64'(st), 64'd5);
      check("post_ram", ram[8], ref_ram[8]);
      @(posedge clk); #1;
`endif

      for (int n = 0; n < 60; n++) begin
         r = 1'($urandom_range(0, 1));
`ifdef DATA_MEM_CTRL_POSTED_WRITE_EN
         w = 1'b0;
`else
         w = 1'($urandom_range(0, 1));
`endif
         if (!r && !w) r = 1'b1;
         kind = int'($urandom_range(0, 9));
         a = 64'($urandom_range(0, NW - 1)) << 3;
         if (kind == 0) a = a | 64'($urandom_range(1, 7));
         else if (kind == 1) a = a | (64'd1 << $urandom_range(8, 63));
         dly = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 4));
         access(r, w, a, {$urandom, $urandom}, dly);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Load/store access unit between the single-cycle CPU's memory-control outputs and a variable-latency doubleword data RAM.
- Converts the CPU's level-style memory controls into a request/acknowledge transaction to the RAM.
- Stalls the CPU until the access completes and checks every access for address faults.
- Replaces the CPU's direct combinational coupling to data memory.

Parameters:
- ADDR_W, 5: doubleword index width; RAM holds 2^ADDR_W x 64-bit words.
- TIMEOUT, 15: maximum number of cycles in REQ waiting for MEM_ACK before a bus fault.

Ports:
- CLOCK  in  1  rising-edge clock.
- RESET_N  in  1  synchronous, active-low reset.
- CPU_MEMREAD  in  1  load request, held by the CPU while STALL=1.
- CPU_MEMWRITE  in  1  store request, held by the CPU while STALL=1.
- CPU_ADDRESS  in  64  byte address (ALU result).
- CPU_WDATA  in  64  store data.
- CPU_RDATA  out  64  load data, valid in the DONE cycle.
- STALL  out  1  CPU must hold PC and all request inputs while high.
- FAULT  out  1  one-cycle pulse: misaligned, out-of-range or timed-out access.
- MEM_REQ  out  1  RAM request, held until acknowledged.
- MEM_WE  out  1  1 = write, 0 = read; stable while MEM_REQ=1.
- MEM_ADDR  out  ADDR_W  doubleword index.
- MEM_WDATA  out  64  RAM write data.
- MEM_ACK  in  1  RAM completion, single cycle.
- MEM_RDATA  in  64  RAM read data, valid with MEM_ACK.

Behaviour:
- Reset values (RESET_N=0 at a rising edge): state=IDLE; MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, CPU_RDATA=0, FAULT=0, timeout counter=0. STALL is then 0.
- Reset mid-transaction abandons the access; MEM_REQ is low from the cycle after that edge.
- A request exists when CPU_MEMREAD|CPU_MEMWRITE. If both are high, it is a write; MEM_WE=1.
- Fault checks, applied in IDLE:
  - misaligned: CPU_ADDRESS[2:0]!=0
  - out of range: CPU_ADDRESS[63:ADDR_W+3]!=0
  - a faulting access never reaches the RAM.
- Index mapping: MEM_ADDR = CPU_ADDRESS[ADDR_W+2:3].
- STALL (combinational) = (IDLE & request & no fault) | REQ. STALL is 0 in DONE, FAULT and IDLE-without-request.
- State IDLE:
  - request with fault -> FAULT state.
  - request without fault -> register address, data and type; go to REQ.
- State REQ:
  - MEM_REQ=1; the counter increments each cycle.
  - MEM_ACK=1 -> capture MEM_RDATA into CPU_RDATA (for reads); go to DONE.
  - counter==TIMEOUT-1 with no ack -> CPU_RDATA=0; go to FAULT.
- State DONE: lasts one cycle; the CPU advances on this edge; go to IDLE. CPU_RDATA holds until the next load completes.
- State FAULT: FAULT=1 for one cycle; CPU_RDATA=0 for a faulting load; go to IDLE.
- Minimum load latency: request in cycle N, MEM_REQ in N+1, ack in N+1, data in N+2. That is 2 stall cycles.
- Back-to-back identical requests are separate accesses. The DONE cycle guarantees one transaction per instruction.
- MEM_ACK outside REQ is ignored.

Optional Feature:
- Macro: DATA_MEM_CTRL_POSTED_WRITE_EN.
- Enabled:
  - one-entry write buffer: a fault-free store in IDLE with the buffer empty is latched, with STALL=0 (zero-stall store).
  - the buffer drains via REQ in the background.
  - any new request while the buffer is busy stalls until the drain ack.
  - a drain timeout pulses FAULT once.
- Disabled: every store blocks, exactly as described above.

Decomposition:
- Package data_mem_pkg holds:
  - state enum (IDLE, REQ, DONE, FAULT)
  - DWORD_W=64 and BYTE_OFF_W=3
  - a fault-check function.
- One natural sub-module: data_mem_wbuf, the posted-write buffer, instantiated only under the macro.

Test Plan:
- Load, RAM acks in the first REQ cycle: CPU_MEMREAD=1, CPU_ADDRESS=0x50, RAM[10]=1540 -> MEM_ADDR=10, STALL high 2 cycles, CPU_RDATA=1540 in DONE.
- Store with ack delayed 3 cycles: CPU_MEMWRITE=1, CPU_ADDRESS=0x38, CPU_WDATA=4 -> MEM_WE=1, MEM_ADDR=7, MEM_REQ held 4 cycles, STALL 5 cycles, RAM[7]=4.
- Misaligned load: CPU_ADDRESS=0x51 -> FAULT pulse, MEM_REQ never 1, CPU_RDATA=0, STALL=0.
- Out-of-range: CPU_ADDRESS=0x100 with ADDR_W=5 -> FAULT pulse, no RAM access.
- Timeout: MEM_ACK tied 0 -> MEM_REQ high exactly 15 cycles, then FAULT pulse, return to IDLE.
- Reset mid-REQ: RESET_N=0 for one edge -> MEM_REQ=0 and STALL=0 next cycle. A late MEM_ACK afterwards is ignored.
- Posted write (with macro): store then load back-to-back -> store STALL=0; load stalls until drain ack, then reads the new value.
